// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the multiplexed 7-segment display scanner:
//   - scan_state_t : per-slot phase (blank gap, then digit shown)
//   - SEG_OFF      : all segments dark on active-low segment pins
//   - DIG_OFF      : no digit selected on active-low select pins
//   - HEX_SEG      : active-high segment patterns for hex 0..F (bit 0 = a)
//   - cnt_width    : width of a counter able to hold 0..max(a,b)-1
// -----------------------------------------------------------------------------
package display_pkg;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] DIG_OFF = 4'hF;

  // Segment order g f e d c b a, so bit 0 is segment a.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hex7seg.sv
// -----------------------------------------------------------------------------
// hex7seg
// Combinational hex nibble to 7-segment decoder, active-high outputs.
// Ports:
//   nibble : 4-bit hex value to display
//   seg    : 7-bit segment pattern, bit 0 = segment a, 1 = lit
// -----------------------------------------------------------------------------
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
// Each digit slot is a BLANK gap of BLANK_CYCLES followed by a SHOW phase of
// SCAN_DIV cycles. New values are staged in a shadow register and committed
// only at frame end so a frame never mixes old and new digits.
// Parameters:
//   SCAN_DIV     : cycles per SHOW phase (2..65535)
//   BLANK_CYCLES : cycles per BLANK phase (1..255)
// Ports:
//   i_clock    : clock, rising edge
//   i_reset    : synchronous active-high reset
//   i_value    : four hex nibbles, [3:0] is digit 0
//   i_load     : one-cycle request to take i_value
//   i_digit_en : per-digit enable, sampled live
//   lcd        : segment pins, active-low, bit 0 = a (registered)
//   digits     : digit select pins, active-low (registered)
//   o_pending  : a loaded value is waiting for frame end
//   o_frame    : one-cycle pulse marking the end of a full scan
// -----------------------------------------------------------------------------
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 12500,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [15:0] i_value,
  input  logic        i_load,
  input  logic [3:0]  i_digit_en,
  output logic [6:0]  lcd,
  output logic [3:0]  digits,
  output logic        o_pending,
  output logic        o_frame
);

  localparam int CNT_W = cnt_width(SCAN_DIV, BLANK_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);

  scan_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       idx, idx_next;
  logic [15:0]      active, shadow;
  logic             frame_end;
  logic [3:0]       cur_nibble;
  logic [6:0]       cur_seg;
  logic [6:0]       lcd_next;
  logic [3:0]       digits_next;

  assign cur_nibble = active[{idx, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Phase sequencing and pin decode. The counter restarts at every phase
  // change; frame end is the final SHOW cycle of digit 3.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt + 1'b1;
    idx_next    = idx;
    frame_end   = 1'b0;
    lcd_next    = SEG_OFF;
    digits_next = DIG_OFF;

    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_next = ST_SHOW;
          cnt_next   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_next = ST_BLANK;
          cnt_next   = '0;
          idx_next   = idx + 2'd1;
          frame_end  = (idx == 2'd3);
        end
      end
      default: begin
        state_next = ST_BLANK;
        cnt_next   = '0;
      end
    endcase

    // A disabled digit still uses its slot time but stays dark.
    if (state == ST_SHOW && i_digit_en[idx]) begin
      lcd_next    = ~cur_seg;
      digits_next = ~(4'b0001 << idx);
    end
  end

  // State register plus registered pins, so the pins trail the FSM by one
  // cycle. A load landing on the frame-end cycle bypasses the shadow.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= ST_BLANK;
      cnt       <= '0;
      idx       <= 2'd0;
      active    <= 16'h0000;
      shadow    <= 16'h0000;
      o_pending <= 1'b0;
      o_frame   <= 1'b0;
      lcd       <= SEG_OFF;
      digits    <= DIG_OFF;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      idx     <= idx_next;
      o_frame <= frame_end;
      lcd     <= lcd_next;
      digits  <= digits_next;

      if (frame_end) begin
        if (i_load) begin
          active    <= i_value;
          o_pending <= 1'b0;
        end else if (o_pending) begin
          active    <= shadow;
          o_pending <= 1'b0;
        end
      end else if (i_load) begin
        shadow    <= i_value;
        o_pending <= 1'b1;
      end
    end
  end

endmodule
